// File: rtl/if_fetch_queue.sv
// if_fetch_queue: decoupling FIFO of fetch packets between IF and ID.
// Each entry holds {pc, instr, predicted-taken, predicted-target} (97 bits).
// Backpressure (if_ready) depends only on registered occupancy, so there is
// no combinational path from decode back into fetch.
// Optional build macro FETCHQ_BYPASS_EN: an empty queue forwards the incoming
// fetch packet straight to the id_* outputs (zero-cycle latency); a packet
// consumed that way is never written.
module if_fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       if_valid,
  input  logic [31:0]                pc_if,
  input  logic [31:0]                instr_if,
  input  logic                       predictedTaken_if,
  input  logic [31:0]                predictedTarget_if,
  output logic                       if_ready,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [31:0]                pc_id,
  output logic [31:0]                instr_id,
  output logic                       predictedTaken_id,
  output logic [31:0]                predictedTarget_id,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        taken;
    logic [31:0] target;
  } pkt_t;

  pkt_t          mem [DEPTH];
  pkt_t          in_pkt;
  pkt_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          byp;
  logic          enq;
  logic          deq;

  assign in_pkt   = '{pc: pc_if, instr: instr_if, taken: predictedTaken_if,
                      target: predictedTarget_if};
  assign empty    = (count == '0);
  assign if_ready = (count != CW'(DEPTH));

`ifdef FETCHQ_BYPASS_EN
  // Forward through an empty queue; gated by reset so reset outputs stay clean.
  assign byp = rst & empty & if_valid & ~flush;
`else
  assign byp = 1'b0;
`endif

  // A bypassed packet taken by decode in the same cycle is not stored.
  assign enq = if_valid & if_ready & ~flush & ~(byp & id_ready);
  assign deq = ~empty & id_ready & ~flush;

  // Entry storage; contents are don't-care while not counted as occupied.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= in_pkt;
  end

  // Pointers and occupancy; flush wins over simultaneous enqueue/dequeue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head selection: stored entry, bypassed input, or idle NOP bubble.
  always_comb begin
    head     = '{pc: 32'h0, instr: NOP_INSTR, taken: 1'b0, target: 32'h0};
    id_valid = 1'b0;
    if (!empty) begin
      head     = mem[rd_ptr];
      id_valid = 1'b1;
    end else if (byp) begin
      head     = in_pkt;
      id_valid = 1'b1;
    end
  end

  assign pc_id              = head.pc;
  assign instr_id           = head.instr;
  assign predictedTaken_id  = head.taken;
  assign predictedTarget_id = head.target;

endmodule
